lab7_2_spi_slave: RTL and testbench

SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) with an Avalon-style CPU register port. It is the far-end peer of the system's SPI master and is used for loopback and bring-up of the master on-chip. SCLK, SS_n and MOSI are oversampled in the clk domain; received bytes go to a holding register, and transmit bytes come from a CPU-loaded holding register.

---
 rtl/lab7_2_spi_slave_pkg.sv | 25 ++
 rtl/lab7_2_spi_slave_if.sv | 24 ++
 rtl/lab7_2_spi_slave_sync.sv | 24 ++
 rtl/lab7_2_spi_slave.sv | 192 +++++++++++++++++++
 tb/tb_lab7_2_spi_slave.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab7_2_spi_slave_pkg.sv
// Shared constants and types for the SPI slave: register map, status/control
// bit positions and the frame FSM state type.
package spi_slave_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int unsigned BIT_ROE  = 3;
    localparam int unsigned BIT_TOE  = 4;
    localparam int unsigned BIT_TMT  = 5;
    localparam int unsigned BIT_TRDY = 6;
    localparam int unsigned BIT_RRDY = 7;
    localparam int unsigned BIT_E    = 8;

    // Only the interrupt-enable bits are storable in the control register.
    localparam logic [15:0] CTRL_MASK = 16'h01D8;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_e;

endpackage

// File: rtl/lab7_2_spi_slave_if.sv
// CPU register port of the SPI slave (Avalon-style strobes, irq and flow flags).
interface lab7_2_spi_slave_if;

    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        read_n;
    logic        write_n;
    logic        spi_select;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;

    modport slave (
        input  mem_addr, data_from_cpu, read_n, write_n, spi_select,
        output data_to_cpu, irq, dataavailable, readyfordata
    );

    modport master (
        output mem_addr, data_from_cpu, read_n, write_n, spi_select,
        input  data_to_cpu, irq, dataavailable, readyfordata
    );

endinterface

// File: rtl/lab7_2_spi_slave_sync.sv
// N-stage flip-flop synchronizer with asynchronous reset to a chosen level.
module spi_slave_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/lab7_2_spi_slave.sv
// SPI mode-0 slave, MSB first, with oversampled SPI pins and a CPU register
// port holding one RX byte and one primed TX byte.
module lab7_2_spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned         DATABITS    = 8,
    parameter logic [DATABITS-1:0] TX_IDLE_VAL = 8'hFF,
    parameter int unsigned         SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic SCLK,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_oe,
    lab7_2_spi_slave_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DATABITS) + 1;

    logic                sclk_s, ss_n_s, mosi_s;
    logic                sclk_dly_q, ss_n_dly_q;
    logic                sclk_rise, sclk_fall, ss_fall, ss_rise;
    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATABITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [DATABITS-1:0] rx_holding_q, rx_holding_d, tx_holding_q, tx_holding_d;
    logic                primed_q, primed_d, rrdy_q, rrdy_d, roe_q, roe_d;
    logic                toe_q, toe_d, irq_q, irq_d;
    logic                rd_strobe_q, rd_strobe_d, wr_strobe_q, wr_strobe_d;
    logic [15:0]         ctrl_q, ctrl_d, rdata_q, rdata_d, status_w;
    logic                rd_req, wr_req, reload;

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d_i(SCLK), .q_o(sclk_s));
    spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk(clk), .reset_n(reset_n), .d_i(SS_n), .q_o(ss_n_s));
    spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d_i(MOSI), .q_o(mosi_s));

    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ss_fall   = ~ss_n_s & ss_n_dly_q;
    assign ss_rise   = ss_n_s & ~ss_n_dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_dly_q   <= 1'b0;
            ss_n_dly_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= TX_IDLE_VAL;
            rx_holding_q <= '0;
            tx_holding_q <= '0;
            primed_q     <= 1'b0;
            rrdy_q       <= 1'b0;
            roe_q        <= 1'b0;
            toe_q        <= 1'b0;
            irq_q        <= 1'b0;
            rd_strobe_q  <= 1'b0;
            wr_strobe_q  <= 1'b0;
            ctrl_q       <= '0;
            rdata_q      <= '0;
        end else begin
            sclk_dly_q   <= sclk_s;
            ss_n_dly_q   <= ss_n_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_holding_q <= rx_holding_d;
            tx_holding_q <= tx_holding_d;
            primed_q     <= primed_d;
            rrdy_q       <= rrdy_d;
            roe_q        <= roe_d;
            toe_q        <= toe_d;
            irq_q        <= irq_d;
            rd_strobe_q  <= rd_strobe_d;
            wr_strobe_q  <= wr_strobe_d;
            ctrl_q       <= ctrl_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        status_w           = '0;
        status_w[BIT_ROE]  = roe_q;
        status_w[BIT_TOE]  = toe_q;
        status_w[BIT_TMT]  = ~primed_q & (state_q == IDLE);
        status_w[BIT_TRDY] = ~primed_q;
        status_w[BIT_RRDY] = rrdy_q;
        status_w[BIT_E]    = roe_q | toe_q;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_holding_d = rx_holding_q;
        tx_holding_d = tx_holding_q;
        primed_d     = primed_q;
        rrdy_d       = rrdy_q;
        roe_d        = roe_q;
        toe_d        = toe_q;
        ctrl_d       = ctrl_q;
        rdata_d      = rdata_q;
        reload       = 1'b0;
        irq_d        = |(status_w & ctrl_q);

        // Strobes are held two cycles; the guard makes each access act once.
        rd_req      = bus.spi_select & ~bus.read_n & ~rd_strobe_q;
        wr_req      = bus.spi_select & ~bus.write_n & ~wr_strobe_q;
        rd_strobe_d = rd_req;
        wr_strobe_d = wr_req;

        // Bus clears are applied first so that same-cycle frame sets win.
        if (rd_req) begin
            unique case (bus.mem_addr)
                ADDR_RXDATA: begin
                    rdata_d = 16'(rx_holding_q);
                    rrdy_d  = 1'b0;
                end
                ADDR_STATUS:  rdata_d = status_w;
                ADDR_CONTROL: rdata_d = ctrl_q;
                default:      rdata_d = '0;
            endcase
        end
        if (wr_req && bus.mem_addr == ADDR_STATUS) begin
            roe_d  = 1'b0;
            toe_d  = 1'b0;
            rrdy_d = 1'b0;
        end
        if (wr_req && bus.mem_addr == ADDR_CONTROL) begin
            ctrl_d = bus.data_from_cpu & CTRL_MASK;
        end

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATABITS-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATABITS - 1)) begin
                        rx_holding_d = rx_shift_d;
                        rrdy_d       = 1'b1;
                        roe_d        = roe_d | rrdy_q;
                        bit_cnt_d    = '0;
                        reload       = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall && bit_cnt_q != '0) begin
                    tx_shift_d = {tx_shift_q[DATABITS-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        if (reload) begin
            tx_shift_d = primed_q ? tx_holding_q : TX_IDLE_VAL;
            primed_d   = 1'b0;
        end
        // A reload frees the holding register even if it was primed this cycle.
        if (wr_req && bus.mem_addr == ADDR_TXDATA) begin
            if (primed_q && !reload) begin
                toe_d = 1'b1;
            end else begin
                tx_holding_d = bus.data_from_cpu[DATABITS-1:0];
                primed_d     = 1'b1;
            end
        end
    end

    assign MISO              = tx_shift_q[DATABITS-1];
    assign MISO_oe           = ~ss_n_s;
    assign bus.data_to_cpu   = rdata_q;
    assign bus.irq           = irq_q;
    assign bus.dataavailable = rrdy_q;
    assign bus.readyfordata  = ~primed_q;

endmodule

// File: tb/tb_lab7_2_spi_slave.sv
// Directed-plus-random bench for the SPI slave: a bit-level SPI master model
// and a transaction-level model of the slave's registers and flags.
module tb_lab7_2_spi_slave;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic reset_n, SCLK, SS_n, MOSI, MISO, MISO_oe;

    lab7_2_spi_slave_if bus ();

    lab7_2_spi_slave #(
        .DATABITS(8), .TX_IDLE_VAL(8'hFF), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state of the slave, tracked per transaction.
    logic        m_primed, m_rrdy, m_roe, m_toe, m_active;
    logic [7:0]  m_hold, m_rx;
    logic [15:0] m_ctrl;

    task automatic model_reset();
        m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_active = 0;
        m_hold = '0; m_rx = '0; m_ctrl = '0;
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = '0;
        s[3] = m_roe;
        s[4] = m_toe;
        s[5] = ~m_primed & ~m_active;
        s[6] = ~m_primed;
        s[7] = m_rrdy;
        s[8] = m_roe | m_toe;
        return s;
    endfunction

    function automatic logic m_irq();
        return |(m_status() & m_ctrl);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.spi_select = 1; bus.mem_addr = a; bus.data_from_cpu = d; bus.write_n = 0;
        repeat (2) @(negedge clk);
        bus.write_n = 1; bus.spi_select = 0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.spi_select = 1; bus.mem_addr = a; bus.read_n = 0;
        repeat (2) @(negedge clk);
        d = bus.data_to_cpu;
        bus.read_n = 1; bus.spi_select = 0;
    endtask

    task automatic tx_write(input logic [7:0] v);
        bus_write(ADDR_TXDATA, {8'h00, v});
        if (m_primed) m_toe = 1;
        else begin m_hold = v; m_primed = 1; end
    endtask

    task automatic rx_read(input string tag);
        logic [15:0] d;
        bus_read(ADDR_RXDATA, d);
        check(tag, d, {8'h00, m_rx});
        m_rrdy = 0;
    endtask

    task automatic status_read(input string tag);
        logic [15:0] d;
        bus_read(ADDR_STATUS, d);
        check(tag, d, m_status());
    endtask

    task automatic status_clear();
        bus_write(ADDR_STATUS, 16'h0000);
        m_roe = 0; m_toe = 0; m_rrdy = 0;
    endtask

    task automatic ctrl_write(input logic [15:0] v);
        bus_write(ADDR_CONTROL, v);
        m_ctrl = v;
    endtask

    task automatic spi_begin();
        SS_n = 0; m_active = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        SS_n = 1; m_active = 0;
        repeat (8) @(negedge clk);
    endtask

    // Master side: 20 clk per SCLK period (2.5 MHz at 50 MHz clk).
    task automatic xfer(input int nbits, input logic [7:0] tx,
                        output logic [7:0] rx, output logic [7:0] want);
        want = m_primed ? m_hold : 8'hFF;
        m_primed = 0;
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = tx[i];
            repeat (10) @(negedge clk);
            rx[i] = MISO;
            SCLK = 1;
            repeat (10) @(negedge clk);
            SCLK = 0;
        end
        if (nbits == 8) begin
            m_roe = m_roe | m_rrdy;
            m_rrdy = 1;
            m_rx = tx;
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] tx);
        logic [7:0] rx, want;
        spi_begin();
        xfer(8, tx, rx, want);
        spi_end();
        check(tag, {8'h00, rx}, {8'h00, want});
    endtask

    initial begin
        logic [7:0]  rx, want, b1, b2;
        logic [15:0] d;

        model_reset();
        reset_n = 0; SS_n = 1; SCLK = 0; MOSI = 0;
        bus.spi_select = 0; bus.read_n = 1; bus.write_n = 1;
        bus.mem_addr = '0; bus.data_from_cpu = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", {15'd0, MISO}, 16'h0001);
        check("rst_miso_oe", {15'd0, MISO_oe}, 16'h0000);
        check("rst_irq", {15'd0, bus.irq}, 16'h0000);
        check("rst_rrdy", {15'd0, bus.dataavailable}, 16'h0000);
        check("rst_rdata", bus.data_to_cpu, 16'h0000);
        reset_n = 1;
        repeat (4) @(negedge clk);
        status_read("rst_status");

        // 1: primed A5 out, 3C in.
        tx_write(8'hA5);
        check("t1_trdy", {15'd0, bus.readyfordata}, {15'd0, ~m_primed});
        frame("t1_miso", 8'h3C);
        check("t1_rrdy_set", {15'd0, bus.dataavailable}, {15'd0, m_rrdy});
        rx_read("t1_rxdata");
        check("t1_rrdy_clr", {15'd0, bus.dataavailable}, 16'h0000);
        status_read("t1_status");
        check("t1_status_abs", m_status(), 16'h0060);

        // 2: underrun sends the idle byte; TMT low while selected.
        spi_begin();
        status_read("t2_status_active");
        check("t2_miso_oe", {15'd0, MISO_oe}, 16'h0001);
        xfer(8, 8'($urandom), rx, want);
        spi_end();
        check("t2_miso_idle", {8'h00, rx}, 16'h00FF);
        status_read("t2_status_idle");
        rx_read("t2_rxdata");

        // 3: back-to-back frames, second byte written mid-frame.
        b1 = 8'($urandom); b2 = 8'($urandom);
        tx_write(8'h11);
        spi_begin();
        fork
            xfer(8, b1, rx, want);
            begin repeat (60) @(negedge clk); tx_write(8'h22); end
        join
        check("t3_miso1", {8'h00, rx}, {8'h00, want});
        check("t3_miso1_abs", {8'h00, rx}, 16'h0011);
        rx_read("t3_rxdata1");
        xfer(8, b2, rx, want);
        check("t3_miso2", {8'h00, rx}, 16'h0022);
        spi_end();
        rx_read("t3_rxdata2");
        status_read("t3_status_no_roe");

        // 4: overrun, interrupt on ROE, cleared by status write.
        frame("t4_miso1", 8'($urandom));
        frame("t4_miso2", 8'($urandom));
        ctrl_write(16'h0008);
        check("t4_irq_set", {15'd0, bus.irq}, {15'd0, m_irq()});
        status_read("t4_status_roe");
        bus_read(ADDR_CONTROL, d);
        check("t4_ctrl_rd", d, m_ctrl);
        rx_read("t4_rxdata_second");
        status_clear();
        check("t4_irq_clr", {15'd0, bus.irq}, 16'h0000);
        status_read("t4_status_clr");
        ctrl_write(16'h0000);

        // 5: second TX write while primed flags TOE, first value kept.
        b1 = 8'($urandom);
        tx_write(b1);
        tx_write(8'($urandom));
        status_read("t5_status_toe");
        check("t5_trdy", {15'd0, bus.readyfordata}, 16'h0000);
        frame("t5_miso_first", 8'($urandom));
        status_clear();
        rx_read("t5_rxdata");

        // 6: partial frame discarded, then full frame, then reset mid-frame.
        spi_begin();
        xfer(4, 8'hF0, rx, want);
        spi_end();
        check("t6_partial_rrdy", {15'd0, bus.dataavailable}, 16'h0000);
        frame("t6_miso", 8'h5A);
        ctrl_write(16'h0080);
        check("t6_irq_rrdy", {15'd0, bus.irq}, {15'd0, m_irq()});
        check("t6_rx_abs", {8'h00, m_rx}, 16'h005A);
        spi_begin();
        xfer(3, 8'($urandom), rx, want);
        reset_n = 0;
        #1;
        check("t6_rst_miso_oe", {15'd0, MISO_oe}, 16'h0000);
        check("t6_rst_miso", {15'd0, MISO}, 16'h0001);
        check("t6_rst_rrdy", {15'd0, bus.dataavailable}, 16'h0000);
        check("t6_rst_irq", {15'd0, bus.irq}, 16'h0000);
        SS_n = 1; SCLK = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        model_reset();
        repeat (4) @(negedge clk);
        status_read("t6_status_after_rst");
        bus_read(ADDR_CONTROL, d);
        check("t6_ctrl_after_rst", d, 16'h0000);
        rx_read("t6_rxdata_after_rst");

        // Random mix of priming, frames and register reads.
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            if ($urandom_range(0, 3) == 0) tx_write(8'($urandom));
            frame("rnd_miso", 8'($urandom));
            if ($urandom_range(0, 1) == 1) rx_read("rnd_rxdata");
            status_read("rnd_status");
            if ($urandom_range(0, 2) == 0) status_clear();
        end
        bus_read(3'd5, d);
        check("unused_addr", d, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
